// File: rtl/multicycle_controller.sv
// Control FSM for the shared multi-cycle RISC-V datapath: sequences fetch,
// decode, execute, memory and writeback, and drives datapath selects/enables.
module multicycle_controller #(
  parameter bit EN_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic       instr_done
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECUTER = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_ALUWB    = 4'd10;
  localparam logic [3:0] S_BEQ      = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       pc_update_s;
  logic       branch_s;
  logic [1:0] imm_dec_s;

  // State register; async clear forces IDLE immediately, mid-instruction included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Immediate format from the opcode
  always_comb begin
    case (Op)
      OP_LOAD, OP_IALU: imm_dec_s = 2'b00;
      OP_STORE:         imm_dec_s = 2'b01;
      OP_BEQ:           imm_dec_s = 2'b10;
      OP_JAL:           imm_dec_s = 2'b11;
      default:          imm_dec_s = 2'b00;
    endcase
  end

  // Next-state and Moore/Mealy output decode
  always_comb begin
    state_d     = S_FETCH;
    mem_req     = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = mem_ready;
        pc_update_s = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute branch/jump target into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_IALU:           state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL: begin
            if (EN_JAL) begin
              state_d = S_JAL;
            end else begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        // PC loads the target from ALUOut while PC+4 is formed for rd
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b01;
        branch_s   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate select is live in every reachable non-IDLE state
  always_comb begin
    if ((state_q != S_IDLE) && (state_q <= S_BEQ)) begin
      ImmSrc = imm_dec_s;
    end else begin
      ImmSrc = 2'b00;
    end
  end

  assign PCWrite = pc_update_s | (branch_s & Zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the packed control outputs to hand-written values.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal_op, instr_done;

  int total;
  int bad;

  multicycle_controller #(.EN_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal_op(illegal_op), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: mreq adr irw pcw mw rw rs[2] sa[2] sb[2] aluop[2] imm[2] ill done
  function automatic logic [17:0] mk(input logic mreq, input logic adr, input logic irw,
                                     input logic pcw, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] op,
                                     input logic [1:0] imm, input logic ill,
                                     input logic done);
    return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, op, imm, ill, done};
  endfunction

  function automatic logic [17:0] obs();
    return {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, instr_done};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  // Drive inputs after a falling edge, then compare outputs for this cycle
  task automatic cyc(input string tag, input logic mr, input logic [6:0] op,
                     input logic z, input logic [17:0] exp);
    @(negedge clk);
    mem_ready = mr;
    Op        = op;
    Zero      = z;
    #1;
    check(tag, obs(), exp);
  endtask

  localparam logic [17:0] ZERO18 = 18'h0;

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    Op        = 7'b0010011;
    Zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset and first fetch, then an addi through EXECUTEI
    cyc("in_reset", 1'b1, 7'b0010011, 1'b0, ZERO18);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle", obs(), ZERO18);
    cyc("addi_fetch", 1'b1, 7'b0010011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("addi_dec",   1'b1, 7'b0010011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0));
    cyc("addi_exe",   1'b1, 7'b0010011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0,0));
    cyc("addi_wb",    1'b1, 7'b0010011, 1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,1));

    // Load with two wait cycles in FETCH and in MEMREAD
    cyc("lw_fwait0", 1'b0, 7'b0000011, 1'b0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("lw_fwait1", 1'b0, 7'b0000011, 1'b0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("lw_fetch",  1'b1, 7'b0000011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("lw_dec",    1'b0, 7'b0000011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0));
    cyc("lw_adr",    1'b0, 7'b0000011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0,0));
    cyc("lw_rwait0", 1'b0, 7'b0000011, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0));
    cyc("lw_rwait1", 1'b0, 7'b0000011, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0));
    cyc("lw_read",   1'b1, 7'b0000011, 1'b0, mk(1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0));
    cyc("lw_wb",     1'b1, 7'b0000011, 1'b0, mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,0,1));

    // beq taken then not taken
    cyc("beqt_fetch", 1'b1, 7'b1100011, 1'b1, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b10,0,0));
    cyc("beqt_dec",   1'b1, 7'b1100011, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0));
    cyc("beqt_beq",   1'b1, 7'b1100011, 1'b1, mk(0,0,0,1,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1));
    cyc("beqn_fetch", 1'b1, 7'b1100011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b10,0,0));
    cyc("beqn_dec",   1'b1, 7'b1100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0,0));
    cyc("beqn_beq",   1'b1, 7'b1100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,0,1));

    // Store with one write wait, then R-type
    cyc("sw_fetch", 1'b1, 7'b0100011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0));
    cyc("sw_dec",   1'b1, 7'b0100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0));
    cyc("sw_adr",   1'b1, 7'b0100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0));
    cyc("sw_wwait", 1'b0, 7'b0100011, 1'b0, mk(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0));
    cyc("sw_write", 1'b1, 7'b0100011, 1'b0, mk(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,1));
    cyc("r_fetch",  1'b1, 7'b0110011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("r_dec",    1'b1, 7'b0110011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0,0));
    cyc("r_exe",    1'b1, 7'b0110011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0,0));
    cyc("r_wb",     1'b1, 7'b0110011, 1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,0,1));

    // Illegal opcode, then jal (its FETCH also proves the return from DECODE)
    cyc("ill_fetch", 1'b1, 7'b1110011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b00,0,0));
    cyc("ill_dec",   1'b1, 7'b1110011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,1,0));
    cyc("jal_fetch", 1'b1, 7'b1101111, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b11,0,0));
    cyc("jal_dec",   1'b1, 7'b1101111, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0,0));
    cyc("jal_jal",   1'b1, 7'b1101111, 1'b0, mk(0,0,0,1,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0,0));
    cyc("jal_wb",    1'b1, 7'b1101111, 1'b0, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b11,0,1));

    // Asynchronous reset in the middle of a stalled store
    cyc("rsw_fetch", 1'b1, 7'b0100011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0));
    cyc("rsw_dec",   1'b1, 7'b0100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0,0));
    cyc("rsw_adr",   1'b0, 7'b0100011, 1'b0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0,0));
    cyc("rsw_wwait", 1'b0, 7'b0100011, 1'b0, mk(1,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,2'b01,0,0));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", obs(), ZERO18);
    @(negedge clk);
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("rst_idle", obs(), ZERO18);
    cyc("rst_fetch", 1'b1, 7'b0100011, 1'b0, mk(1,0,1,1,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
